// File: rtl/flit_injector.sv
// flit_injector: packet-to-flit source for one node injection port.
// Accepts packet requests, serialises them into 83-bit flits with deterministic
// payloads, and paces emission with credits returned by the injection buffer.
module flit_injector #(
  parameter int unsigned FLIT_SIZE = 82,
  parameter int unsigned CREDITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_dst_x,
  input  logic [2:0]           req_dst_y,
  input  logic [2:0]           req_dst_z,
  input  logic [7:0]           req_len,
  input  logic [63:0]          req_base,
  output logic [FLIT_SIZE:0]   inject_flit,
  input  logic                 credit_in,
  output logic                 pkt_done,
  output logic [15:0]          pkts_sent,
  output logic                 cred_err
);

  localparam logic [3:0] CredMax = 4'(CREDITS);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e       state_q;
  logic [2:0]   dst_x_q, dst_y_q, dst_z_q;
  logic [7:0]   len_q;
  logic [7:0]   idx_q;
  logic [63:0]  base_q;
  logic [6:0]   seq_q;
  logic [3:0]   credits_q;
  logic [3:0]   credits_d;
  logic         cred_ovf;

  logic               emit;
  logic               last;
  logic [1:0]         flit_type;
  logic [63:0]        payload;
  logic [FLIT_SIZE:0] flit_next;
  logic [7:0]         len_eff;

  // Ready depends on state alone so upstream never sees a valid->ready path.
  assign req_ready = (state_q == StIdle);

  // Current flit contents and emission condition.
  always_comb begin
    emit    = (state_q == StSend) && (credits_q != 4'd0);
    last    = (idx_q == len_q - 8'd1);
    len_eff = (req_len == 8'd0) ? 8'd1 : req_len;
    if (len_q == 8'd1)       flit_type = 2'b11;
    else if (idx_q == 8'd0)  flit_type = 2'b01;
    else if (last)           flit_type = 2'b10;
    else                     flit_type = 2'b00;
    // Head carries the length so a checker can size the packet up front.
    if (idx_q == 8'd0) payload = {len_q, base_q[55:0]};
    else               payload = base_q + {56'd0, idx_q};
    flit_next = {1'b1, flit_type, dst_x_q, dst_y_q, dst_z_q, seq_q, payload};
  end

  // Credit counter next state; a return while full is a protocol error.
  always_comb begin
    credits_d = credits_q;
    cred_ovf  = 1'b0;
    if (emit && !credit_in) begin
      credits_d = credits_q - 4'd1;
    end else if (!emit && credit_in) begin
      if (credits_q == CredMax) cred_ovf = 1'b1;
      else                      credits_d = credits_q + 4'd1;
    end
  end

  // Request/send FSM with registered flit and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      dst_z_q     <= '0;
      len_q       <= 8'd1;
      idx_q       <= '0;
      base_q      <= '0;
      seq_q       <= '0;
      credits_q   <= CredMax;
      inject_flit <= '0;
      pkt_done    <= 1'b0;
      pkts_sent   <= '0;
      cred_err    <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      if (cred_ovf) cred_err <= 1'b1;
      // Idle cycles drive an all-zero flit, never stale fields.
      inject_flit <= '0;
      pkt_done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            dst_x_q <= req_dst_x;
            dst_y_q <= req_dst_y;
            dst_z_q <= req_dst_z;
            len_q   <= len_eff;
            base_q  <= req_base;
            idx_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (emit) begin
            inject_flit <= flit_next;
            idx_q       <= idx_q + 8'd1;
            if (last) begin
              pkt_done  <= 1'b1;
              pkts_sent <= pkts_sent + 16'd1;
              seq_q     <= seq_q + 7'd1;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_injector.sv
// Testbench for flit_injector: randomized and directed stimulus checked against
// a queue-based packet model.
module tb_flit_injector;
  localparam int unsigned FS = 82;
  localparam int          CR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_dst_x, req_dst_y, req_dst_z;
  logic [7:0]    req_len;
  logic [63:0]   req_base;
  logic [FS:0]   inject_flit;
  logic          credit_in;
  logic          pkt_done;
  logic [15:0]   pkts_sent;
  logic          cred_err;

  int tests = 0;
  int fails = 0;

  // Model: every accepted packet becomes a list of expected flits.
  logic [FS:0] mq[$];
  int          m_cred;
  bit          m_err;
  logic [15:0] m_pkts;
  logic [6:0]  m_seq;
  logic [FS:0] e_flit;
  bit          e_done;

  flit_injector #(.FLIT_SIZE(FS), .CREDITS(CR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dst_x   (req_dst_x),
    .req_dst_y   (req_dst_y),
    .req_dst_z   (req_dst_z),
    .req_len     (req_len),
    .req_base    (req_base),
    .inject_flit (inject_flit),
    .credit_in   (credit_in),
    .pkt_done    (pkt_done),
    .pkts_sent   (pkts_sent),
    .cred_err    (cred_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FS:0] mk_flit(input logic [2:0] x, input logic [2:0] y,
                                          input logic [2:0] z, input logic [6:0] s,
                                          input logic [7:0] len, input logic [63:0] base,
                                          input int i);
    logic [1:0]  t;
    logic [63:0] p;
    if (len == 8'd1)            t = 2'b11;
    else if (i == 0)            t = 2'b01;
    else if (i == int'(len) - 1) t = 2'b10;
    else                        t = 2'b00;
    p = (i == 0) ? {len, base[55:0]} : base + 64'(i);
    return {1'b1, t, x, y, z, s, p};
  endfunction

  function automatic logic [101:0] exp_vec();
    return {mq.size() == 0, e_done, m_err, m_pkts, e_flit};
  endfunction

  function automatic logic [101:0] obs_vec();
    return {req_ready, pkt_done, cred_err, pkts_sent, inject_flit};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cred = CR;
    m_err  = 1'b0;
    m_pkts = '0;
    m_seq  = '0;
    e_flit = '0;
    e_done = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_dst_z = '0;
    req_len = '0; req_base = '0; credit_in = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample after it.
  task automatic tick(input bit v, input logic [2:0] x, input logic [2:0] y,
                      input logic [2:0] z, input logic [7:0] len, input logic [63:0] base,
                      input bit cr);
    bit         ready;
    bit         emit;
    logic [7:0] l;
    req_valid = v; req_dst_x = x; req_dst_y = y; req_dst_z = z;
    req_len = len; req_base = base; credit_in = cr;
    ready  = (mq.size() == 0);
    emit   = !ready && (m_cred > 0);
    e_flit = '0;
    e_done = 1'b0;
    if (emit) begin
      e_flit = mq.pop_front();
      if (e_flit[81]) begin
        e_done = 1'b1;
        m_pkts = m_pkts + 16'd1;
        m_seq  = m_seq + 7'd1;
      end
    end
    if (emit && !cr)      m_cred = m_cred - 1;
    else if (!emit && cr) begin
      if (m_cred == CR) m_err = 1'b1;
      else              m_cred = m_cred + 1;
    end
    if (ready && v) begin
      l = (len == 8'd0) ? 8'd1 : len;
      for (int i = 0; i < int'(l); i++) mq.push_back(mk_flit(x, y, z, m_seq, l, base, i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit cr);
    tick(1'b0, 3'd0, 3'd0, 3'd0, 8'd0, 64'd0, cr);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b0; credit_in = 1'b0;
    #3;
    tests++;
    if (obs_vec() !== {1'b1, 1'b0, 1'b0, 16'h0, 83'h0}) begin
      fails++;
      $display("FAIL reset_values got=%h want=%h", obs_vec(), {1'b1, 1'b0, 1'b0, 16'h0, 83'h0});
    end
    do_reset();
    idle(1'b0);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    logic [FS:0] want;
    do_reset();
    tick(1'b1, 3'd1, 3'd0, 3'd1, 8'd1, 64'h10, 1'b0);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL single_accept got=%h want=%h", obs_vec(), exp_vec());
    end
    idle(1'b0);
    want = {1'b1, 2'b11, 3'd1, 3'd0, 3'd1, 7'd0, 8'h01, 56'h10};
    tests++;
    if (inject_flit !== want || pkt_done !== 1'b1 || pkts_sent !== 16'd1) begin
      fails++;
      $display("FAIL single_flit got=%h/%b/%0d want=%h/1/1", inject_flit, pkt_done, pkts_sent, want);
    end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL single_model c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      idle(1'b0);
    end
    // Three credits remain: a 5-flit packet must stall after exactly three flits.
    tick(1'b1, 3'd2, 3'd2, 3'd2, 8'd5, 64'h99, 1'b0);
    for (int c = 0; c < 6; c++) begin
      idle(1'b0);
      tests++;
      if (inject_flit[82] !== (c < 3)) begin
        fails++; $display("FAIL single_credits c=%0d got=%b want=%b", c, inject_flit[82], c < 3);
      end
    end
  endtask

  task automatic test_credit_stall();
    logic [63:0] base;
    base = {$urandom, $urandom};
    do_reset();
    tick(1'b1, 3'd3, 3'd4, 3'd5, 8'd6, base, 1'b0);
    for (int c = 0; c < 6; c++) begin
      idle(1'b0);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== (c < 4)) begin
        fails++; $display("FAIL stall_flit c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    for (int k = 0; k < 2; k++) begin
      idle(1'b1);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== 1'b0) begin
        fails++; $display("FAIL stall_credit_edge k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      idle(1'b0);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== 1'b1) begin
        fails++; $display("FAIL stall_resume k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (inject_flit[81:80] !== 2'b10 || inject_flit[63:0] !== base + 64'd5) begin
      fails++;
      $display("FAIL stall_tail got=%b/%h want=10/%h", inject_flit[81:80], inject_flit[63:0],
               base + 64'd5);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1'b1, 3'd7, 3'd0, 3'd6, 8'd40, 64'h1234, 1'b0);
    for (int c = 0; c < 3; c++) idle(1'b0);
    for (int c = 0; c < 20; c++) begin
      idle(1'b1);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== 1'b1) begin
        fails++; $display("FAIL simul c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit prev_done;
    do_reset();
    prev_done = 1'b0;
    for (int c = 0; c < 120; c++) begin
      tick(1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom_range(0, 4)),
           {$urandom, $urandom}, m_cred < CR);
      tests++;
      if (obs_vec() !== exp_vec() || (prev_done && inject_flit[82] !== 1'b0)) begin
        fails++; $display("FAIL b2b c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      prev_done = pkt_done;
    end
  endtask

  task automatic test_seq_wrap();
    int k;
    int c;
    do_reset();
    k = 0;
    c = 0;
    while (m_pkts != 16'd129 && c < 1000) begin
      tick(m_pkts < 16'd129 - 16'(mq.size() != 0), 3'd1, 3'd1, 3'd1, 8'd1, 64'(c), m_cred < CR);
      c++;
      if (inject_flit[82]) begin
        tests++;
        if (inject_flit[70:64] !== 7'(k) || obs_vec() !== exp_vec()) begin
          fails++; $display("FAIL seq_wrap k=%0d got=%0d want=%0d", k, inject_flit[70:64], 7'(k));
        end
        k++;
      end
    end
    idle(1'b0);
    tests++;
    if (pkts_sent !== 16'd129 || k != 129) begin
      fails++; $display("FAIL seq_wrap_count got=%0d/%0d want=129", pkts_sent, k);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      tick($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
           8'($urandom_range(0, 9)), {$urandom, $urandom},
           ($urandom_range(0, 2) != 0) && (m_cred < CR));
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    idle(1'b1);
    tests++;
    if (cred_err !== 1'b1 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL overflow_set got=%b want=1", cred_err);
    end
    // Counter must have held at the maximum: six-flit packet yields four flits.
    tick(1'b1, 3'd0, 3'd1, 3'd2, 8'd6, 64'hABC, 1'b0);
    for (int c = 0; c < 7; c++) begin
      idle(1'b0);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== (c < 4) || cred_err !== 1'b1) begin
        fails++; $display("FAIL overflow_hold c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 3'd5, 3'd5, 3'd5, 8'd5, 64'h777, 1'b0);
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    #2;
    tests++;
    if (obs_vec() !== {1'b1, 1'b0, 1'b0, 16'h0, 83'h0}) begin
      fails++; $display("FAIL reset_mid_async got=%h want=%h", obs_vec(),
                        {1'b1, 1'b0, 1'b0, 16'h0, 83'h0});
    end
    do_reset();
    tick(1'b1, 3'd2, 3'd3, 3'd4, 8'd2, 64'h55, 1'b0);
    idle(1'b0);
    tests++;
    if (inject_flit !== {1'b1, 2'b01, 3'd2, 3'd3, 3'd4, 7'd0, 8'd2, 56'h55}) begin
      fails++; $display("FAIL reset_mid_head got=%h", inject_flit);
    end
    // Full credit pool after reset: four-flit packet after the 2-flit one stalls at two.
    idle(1'b0);
    tick(1'b1, 3'd1, 3'd1, 3'd1, 8'd4, 64'h9, 1'b0);
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      tests++;
      if (obs_vec() !== exp_vec() || inject_flit[82] !== (c < 2)) begin
        fails++; $display("FAIL reset_mid_cred c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_simultaneous();
    test_back_to_back();
    test_seq_wrap();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
